para_report: RTL and testbench

PARA_REPORT -- requirements
Module: para_report

---
 rtl/para_pkg.sv | 50 +++++
 rtl/para_report_timer.sv | 27 ++
 rtl/para_report.sv | 122 ++++++++++++
 tb/tb_para_report.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/para_pkg.sv
// Shared constants, state encoding and payload layout for the CAN status reporter.
package para_pkg;

  localparam logic [10:0] TX_ID_DEF      = 11'h181;
  localparam int unsigned PERIOD_CYC_DEF = 25_000_000;
  localparam int unsigned GAP_CYC_DEF    = 50_000;
  localparam int unsigned TMO_CYC_DEF    = 500_000;

  // Byte positions inside the 64-bit payload; byte0 is transmitted first.
  localparam int B_CTRL   = 56;
  localparam int B_ID_SET = 48;
  localparam int B_DT     = 40;
  localparam int B_TS_HI  = 32;
  localparam int B_TS_LO  = 24;
  localparam int B_TON    = 16;
  localparam int B_T_NEG  = 8;
  localparam int B_SEQ    = 0;
  localparam int VEC_LSB  = B_T_NEG;
  localparam int VEC_W    = 64 - VEC_LSB;

  // IDLE: wait for a trigger, SEND: frame offered, GAP: enforced idle time
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [63:0] pack_frame(
    input logic [7:0]  ctrl,
    input logic [7:0]  id_set,
    input logic [7:0]  dt,
    input logic [15:0] ts,
    input logic [7:0]  ton,
    input logic [7:0]  t_neg,
    input logic [7:0]  seq
  );
    logic [63:0] f;
    f = '0;
    f[B_CTRL   +: 8] = ctrl;
    f[B_ID_SET +: 8] = id_set;
    f[B_DT     +: 8] = dt;
    f[B_TS_HI  +: 8] = ts[15:8];
    f[B_TS_LO  +: 8] = ts[7:0];
    f[B_TON    +: 8] = ton;
    f[B_T_NEG  +: 8] = t_neg;
    f[B_SEQ    +: 8] = seq;
    return f;
  endfunction

endpackage

// File: rtl/para_report_timer.sv
// Loadable down-counter; done is high for the single cycle in which the count is 1,
// so a load of N makes done appear N-1 cycles later and the owner reacts on the Nth edge.
module para_report_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/para_report.sv
// Status frame reporter: snapshots display parameters into a CAN frame on request,
// on a period tick or on any change, with handshake timeout and inter-frame gap.
module para_report
  import para_pkg::*;
#(
  parameter logic [10:0] TX_ID      = TX_ID_DEF,
  parameter int unsigned PERIOD_CYC = PERIOD_CYC_DEF,
  parameter int unsigned GAP_CYC    = GAP_CYC_DEF,
  parameter int unsigned TMO_CYC    = TMO_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        power_start,
  input  logic        panglu,
  input  logic        vneg,
  input  logic [3:0]  mode,
  input  logic [7:0]  id_set,
  input  logic [7:0]  dt,
  input  logic [7:0]  ton,
  input  logic [7:0]  t_neg,
  input  logic [15:0] ts,
  input  logic        report_req,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [10:0] tx_id,
  output logic [3:0]  tx_dlc,
  output logic [63:0] tx_data,
  output logic [7:0]  tmo_cnt
);

  localparam int unsigned TMR_MAX = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
  localparam int TW = $clog2(TMR_MAX + 1);
  localparam int PW = $clog2(PERIOD_CYC + 1);

  state_t            state, state_nx;
  logic [7:0]        seq;
  logic [PW-1:0]     period_cnt;
  logic [VEC_W-1:0]  last_sent;
  logic [63:0]       cur_frame;
  logic              pending, start, hs, tmo, period_hit, changed, trig;
  logic              tmr_load, tmr_done;
  logic [TW-1:0]     tmr_val;

  assign cur_frame  = pack_frame({power_start, panglu, vneg, 1'b0, mode},
                                 id_set, dt, ts, ton, t_neg, seq);
  assign changed    = (cur_frame[63:VEC_LSB] != last_sent);
  assign period_hit = (period_cnt == PW'(PERIOD_CYC - 1));
  assign hs         = (state == ST_SEND) && tx_ready;
  assign tmo        = (state == ST_SEND) && tmr_done && !tx_ready;
  // A change seen during SEND is caught again in GAP, since last_sent then holds the sent frame
  assign trig       = report_req || period_hit || (changed && (state != ST_SEND));

  assign tx_id  = TX_ID;
  assign tx_dlc = 4'd8;

  para_report_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (pending || trig) begin
          state_nx = ST_SEND;
          start    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TW'(TMO_CYC);
        end
      end
      ST_SEND: begin
        if (hs || tmo) begin
          state_nx = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYC);
        end
      end
      ST_GAP: begin
        if (tmr_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      seq        <= '0;
      tmo_cnt    <= '0;
      period_cnt <= '0;
      last_sent  <= '0;
      pending    <= 1'b1;
    end else begin
      tx_valid <= (state_nx == ST_SEND);
      if (start) tx_data <= cur_frame;
      if (hs) begin
        seq       <= seq + 8'd1;
        last_sent <= tx_data[63:VEC_LSB];
      end
      if (tmo && (tmo_cnt != 8'hFF)) tmo_cnt <= tmo_cnt + 8'd1;
      if (hs || period_hit) period_cnt <= '0;
      else                  period_cnt <= period_cnt + PW'(1);
      // An aborted frame is retried after the gap
      if (start)             pending <= 1'b0;
      else if (trig || tmo)  pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_para_report.sv
// Directed bench for para_report with shortened period, gap and timeout values.
module tb_para_report;

  localparam int PER = 600;
  localparam int GAP = 20;
  localparam int TMO = 150;
  localparam logic [63:0] BASE20 = 64'h0114_1701_C232_0000;
  localparam logic [63:0] BASE21 = 64'h0115_1701_C232_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        power_start = 1'b0, panglu = 1'b0, vneg = 1'b0;
  logic [3:0]  mode = 4'b0001;
  logic [7:0]  id_set = 8'd20, dt = 8'd23, ton = 8'd50, t_neg = 8'd0;
  logic [15:0] ts = 16'd450;
  logic        report_req = 1'b0, tx_ready = 1'b0;
  logic        tx_valid;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic [7:0]  tmo_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_seq;
  logic [63:0] fdata;
  int          waited;
  bit          ok;

  para_report #(.PERIOD_CYC(PER), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .power_start(power_start), .panglu(panglu), .vneg(vneg),
    .mode(mode), .id_set(id_set), .dt(dt), .ton(ton), .t_neg(t_neg), .ts(ts),
    .report_req(report_req), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_id(tx_id),
    .tx_dlc(tx_dlc), .tx_data(tx_data), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  // Waits (at negedges) for a handshake cycle, captures the payload, then steps past it.
  task automatic wait_frame(input int limit, output logic [63:0] data, output int wt, output bit found);
    found = 1'b0;
    wt    = 0;
    data  = '0;
    for (int i = 0; i <= limit; i++) begin
      if (tx_valid && tx_ready) begin
        data  = tx_data;
        wt    = i;
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (found) @(negedge clk);
  endtask

  task automatic pulse_req();
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i <= limit; i++) begin
      if (tx_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", tx_data); end
    checks++; if (tmo_cnt !== 8'd0) begin errors++; $display("FAIL reset_tmo_cnt: got %0d want 0", tmo_cnt); end
    checks++; if (tx_id !== 11'h181) begin errors++; $display("FAIL tx_id: got %h want 181", tx_id); end
    checks++; if (tx_dlc !== 4'd8) begin errors++; $display("FAIL tx_dlc: got %0d want 8", tx_dlc); end
  endtask

  task automatic test_first_frame();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    wait_frame(5, fdata, waited, ok);
    checks++; if (!ok || fdata !== BASE20) begin errors++; $display("FAIL first_frame: got %h want %h", fdata, BASE20); end
    checks++; if (waited != 1) begin errors++; $display("FAIL first_latency: got %0d want 1", waited); end
    exp_seq = 8'd1;
    pulse_req();
    wait_frame(GAP + 10, fdata, waited, ok);
    checks++; if (!ok || fdata !== {BASE20[63:8], exp_seq}) begin errors++; $display("FAIL second_frame: got %h want %h", fdata, {BASE20[63:8], exp_seq}); end
    exp_seq++;
  endtask

  task automatic test_period();
    for (int k = 0; k < 2; k++) begin
      wait_frame(PER + 10, fdata, waited, ok);
      checks++; if (!ok || (waited + 1) < PER - 1 || (waited + 1) > PER + 1) begin errors++; $display("FAIL period_interval: got %0d want %0d+-1", waited + 1, PER); end
      checks++; if (fdata !== {BASE20[63:8], exp_seq}) begin errors++; $display("FAIL period_data: got %h want %h", fdata, {BASE20[63:8], exp_seq}); end
      exp_seq++;
    end
  endtask

  task automatic test_change_in_send();
    tx_ready = 1'b0;
    pulse_req();
    wait_valid(GAP + 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL change_valid: got no tx_valid want tx_valid"); end
    id_set = 8'd21;
    repeat (100) @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== {BASE20[63:8], exp_seq}) begin errors++; $display("FAIL change_hold: got %b/%h want 1/%h", tx_valid, tx_data, {BASE20[63:8], exp_seq}); end
    tx_ready = 1'b1;
    wait_frame(2, fdata, waited, ok);
    checks++; if (!ok || fdata !== {BASE20[63:8], exp_seq}) begin errors++; $display("FAIL change_first: got %h want %h", fdata, {BASE20[63:8], exp_seq}); end
    exp_seq++;
    wait_frame(GAP + 10, fdata, waited, ok);
    checks++; if (!ok || fdata !== {BASE21[63:8], exp_seq}) begin errors++; $display("FAIL change_followup: got %h want %h", fdata, {BASE21[63:8], exp_seq}); end
    checks++; if (waited != GAP + 1) begin errors++; $display("FAIL change_gap: got %0d want %0d", waited, GAP + 1); end
    exp_seq++;
  endtask

  task automatic test_timeout();
    int cnt;
    tx_ready = 1'b0;
    pulse_req();
    wait_valid(GAP + 10, ok);
    cnt = ok ? 1 : 0;
    for (int i = 0; ok && i < TMO + 20; i++) begin
      @(negedge clk);
      if (tx_valid) cnt++;
      else break;
    end
    checks++; if (cnt != TMO) begin errors++; $display("FAIL tmo_length: got %0d want %0d", cnt, TMO); end
    checks++; if (tmo_cnt !== 8'd1) begin errors++; $display("FAIL tmo_cnt: got %0d want 1", tmo_cnt); end
    tx_ready = 1'b1;
    wait_frame(GAP + 10, fdata, waited, ok);
    checks++; if (!ok || fdata !== {BASE21[63:8], exp_seq}) begin errors++; $display("FAIL tmo_retry: got %h want %h", fdata, {BASE21[63:8], exp_seq}); end
    checks++; if (waited != GAP + 1) begin errors++; $display("FAIL tmo_retry_gap: got %0d want %0d", waited, GAP + 1); end
    exp_seq++;
  endtask

  task automatic test_coalesce();
    int n;
    repeat (3) begin
      pulse_req();
      @(negedge clk);
    end
    wait_frame(GAP + 10, fdata, waited, ok);
    checks++; if (!ok || fdata !== {BASE21[63:8], exp_seq}) begin errors++; $display("FAIL coalesce_frame: got %h want %h", fdata, {BASE21[63:8], exp_seq}); end
    exp_seq++;
    n = 0;
    repeat (3 * GAP) begin
      @(negedge clk);
      if (tx_valid) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL coalesce_extra: got %0d valid cycles want 0", n); end
  endtask

  task automatic test_wrap_and_reset();
    int bad;
    bad = 0;
    report_req = 1'b1;
    while (exp_seq != 8'hFF) begin
      wait_frame(GAP + 10, fdata, waited, ok);
      if (!ok || fdata[7:0] !== exp_seq) bad++;
      exp_seq++;
      if (!ok) break;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL seq_run: got %0d bad frames want 0", bad); end
    wait_frame(GAP + 10, fdata, waited, ok);
    checks++; if (!ok || fdata[7:0] !== 8'hFF) begin errors++; $display("FAIL seq_ff: got %h want ff", fdata[7:0]); end
    wait_frame(GAP + 10, fdata, waited, ok);
    checks++; if (!ok || fdata[7:0] !== 8'h00) begin errors++; $display("FAIL seq_wrap: got %h want 00", fdata[7:0]); end
    report_req = 1'b0;
    tx_ready = 1'b0;
    pulse_req();
    wait_valid(GAP + 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_valid_before: got no tx_valid want tx_valid"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 64'h0 || tmo_cnt !== 8'd0) begin errors++; $display("FAIL rst_async_state: got %h/%0d want 0/0", tx_data, tmo_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    wait_frame(5, fdata, waited, ok);
    checks++; if (!ok || fdata !== BASE21) begin errors++; $display("FAIL rst_first_frame: got %h want %h", fdata, BASE21); end
    checks++; if (waited != 1) begin errors++; $display("FAIL rst_latency: got %0d want 1", waited); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_period();
    test_change_in_send();
    test_timeout();
    test_coalesce();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
